// File: rtl/uart_tx_arbiter_pkg.sv
// Shared encodings for the UART TX packet arbiter: FSM states and the
// header tag nibble sent ahead of each packet when ID headers are enabled.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HDR    = 2'd1,
    ST_STREAM = 2'd2
  } arb_state_e;

  localparam logic [3:0] ARB_HDR_TAG = 4'hA;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the one-hot first requester
// at or after ptr_i, wrapping from NUM_REQ-1 back to 0.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  always_comb begin
    int   idx;
    logic found;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX port among NUM_REQ
// requesters, with idle watchdog. Define UART_ARB_ID_HEADER_EN for ID headers.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int IDLE_TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ*8-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_data_valid,
  input  logic                 i_tx_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(IDLE_TIMEOUT + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] pick;
  logic [PW-1:0]      gidx, pidx;
  logic [7:0]         g_data;
  logic               g_valid, g_last, accept;

  rr_picker #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .req_i (i_req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick)
  );

  always_comb begin
    gidx = '0;
    pidx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) gidx = PW'(k);
      if (pick[k])    pidx = PW'(k);
    end
  end

  assign g_data  = i_req_data[gidx*8 +: 8];
  assign g_valid = i_req_valid[gidx];
  assign g_last  = i_req_last[gidx];

  // Data path is a pure pass-through in STREAM so the UART sees zero added latency.
  always_comb begin
    o_tx_data       = '0;
    o_tx_data_valid = 1'b0;
    o_req_ready     = '0;
    case (state_q)
      ST_STREAM: begin
        o_tx_data       = g_data;
        o_tx_data_valid = g_valid;
        o_req_ready     = grant_q & {NUM_REQ{i_tx_ready}};
      end
`ifdef UART_ARB_ID_HEADER_EN
      ST_HDR: begin
        o_tx_data       = {ARB_HDR_TAG, 4'(gidx)};
        o_tx_data_valid = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign accept = o_tx_data_valid && i_tx_ready;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|i_req_valid) begin
          grant_d = pick;
          ptr_d   = (pidx == PW'(NUM_REQ - 1)) ? '0 : pidx + 1'b1;
          cnt_d   = '0;
`ifdef UART_ARB_ID_HEADER_EN
          state_d = ST_HDR;
`else
          state_d = ST_STREAM;
`endif
        end
      end
`ifdef UART_ARB_ID_HEADER_EN
      ST_HDR: begin
        if (i_tx_ready) begin
          state_d = ST_STREAM;
          cnt_d   = '0;
        end
      end
`endif
      ST_STREAM: begin
        // A last byte always beats a watchdog expiry: accept implies no stall.
        if (accept) begin
          cnt_d = '0;
          if (g_last) begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else if (!g_valid) begin
          if (cnt_q == CW'(IDLE_TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
            grant_d   = '0;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_grant   = grant_q;
  assign o_busy    = (state_q != ST_IDLE);
  assign o_timeout = timeout_q;

endmodule
